// File: rtl/fft_peak_detector.sv
// Scans FFT bins FIRST_BIN..LAST_BIN on each fft_done rising edge; tracks the largest re^2+im^2.
// Edge to peak_valid takes NB+3 cycles. There is no backpressure: edges that arrive while busy are dropped.
module fft_peak_detector #(
  parameter int FIRST_BIN = 1,
  parameter int LAST_BIN  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fft_done,
  output logic [5:0]  fft_read_address,
  input  logic [31:0] fft_data,
  input  logic [31:0] mag_threshold,
  output logic        busy,
  output logic        peak_valid,
  output logic        peak_found,
  output logic [5:0]  peak_bin,
  output logic [31:0] peak_mag
);

  localparam logic [5:0] FIRST_A = 6'(FIRST_BIN);
  localparam logic [5:0] LAST_A  = 6'(LAST_BIN);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

  state_t      state_q, state_d;
  logic        done_q;
  logic        drain_q, drain_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] thr_q;

  logic        vld0_q, vld1_q;
  logic [5:0]  idx0_q, idx1_q;
  logic [31:0] re_sq_q, im_sq_q;

  logic [31:0] best_mag_q, best_mag_d;
  logic [5:0]  best_bin_q, best_bin_d;

  logic [31:0] peak_mag_q;
  logic [5:0]  peak_bin_q;
  logic        peak_found_q;

  logic               start;
  logic               publish;
  logic signed [15:0] re, im;
  logic signed [31:0] re_ext, im_ext, re_sq, im_sq;
  logic [31:0]        sum;

  assign start   = (state_q == IDLE) && fft_done && !done_q;
  assign publish = (state_q == DRAIN) && drain_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      addr_q  <= addr_d;
      done_q  <= fft_done;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d = SCAN;
          addr_d  = FIRST_A;
        end
      end
      SCAN: begin
        if (addr_q == LAST_A) state_d = DRAIN;
        else                  addr_d  = addr_q + 6'd1;
      end
      DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = REPORT;
          addr_d  = '0;
        end
      end
      REPORT: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy             = (state_q == SCAN) || (state_q == DRAIN);
    peak_valid       = (state_q == REPORT);
    fft_read_address = addr_q;
    peak_found       = peak_found_q;
    peak_bin         = peak_bin_q;
    peak_mag         = peak_mag_q;
  end

  assign re     = fft_data[31:16];
  assign im     = fft_data[15:0];
  assign re_ext = 32'(re);
  assign im_ext = 32'(im);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign sum    = re_sq_q + im_sq_q;

  // Strict compare keeps the lower bin on ties since bins arrive in ascending order
  always_comb begin
    best_mag_d = best_mag_q;
    best_bin_d = best_bin_q;
    if (start) begin
      best_mag_d = '0;
      best_bin_d = FIRST_A;
    end else if (vld1_q && (sum > best_mag_q)) begin
      best_mag_d = sum;
      best_bin_d = idx1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld0_q       <= 1'b0;
      vld1_q       <= 1'b0;
      idx0_q       <= '0;
      idx1_q       <= '0;
      re_sq_q      <= '0;
      im_sq_q      <= '0;
      thr_q        <= '0;
      best_mag_q   <= '0;
      best_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      peak_found_q <= 1'b0;
    end else begin
      vld0_q     <= (state_q == SCAN);
      idx0_q     <= addr_q;
      vld1_q     <= vld0_q;
      idx1_q     <= idx0_q;
      re_sq_q    <= re_sq;
      im_sq_q    <= im_sq;
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
      if (start) thr_q <= mag_threshold;
      // The last bin lands in best on this same edge, so publish from the next-state value
      if (publish) begin
        peak_mag_q   <= best_mag_d;
        peak_bin_q   <= best_bin_d;
        peak_found_q <= (best_mag_d > thr_q);
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Bench for fft_peak_detector: spectrum memory model, scoreboard of expected peaks, address/busy monitor.
module tb_fft_peak_detector;

  localparam int FIRST = 1;
  localparam int LAST  = 31;
  localparam int NB    = LAST - FIRST + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        fft_done;
  logic [5:0]  fft_read_address;
  logic [31:0] fft_data;
  logic [31:0] mag_threshold;
  logic        busy, peak_valid, peak_found;
  logic [5:0]  peak_bin;
  logic [31:0] peak_mag;

  fft_peak_detector #(.FIRST_BIN(FIRST), .LAST_BIN(LAST)) dut (
    .clk(clk), .reset(reset), .fft_done(fft_done),
    .fft_read_address(fft_read_address), .fft_data(fft_data),
    .mag_threshold(mag_threshold), .busy(busy), .peak_valid(peak_valid),
    .peak_found(peak_found), .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  bin;
    logic [31:0] mag;
    logic        found;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] spectrum [64];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  int          busy_len = 0;
  int          addr_bad = 0;
  logic [5:0]  exp_addr = 6'(FIRST);
  logic        prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller read port: data appears one cycle after the address
  always @(posedge clk) fft_data <= spectrum[fft_read_address];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_len  = 0;
      addr_bad  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy) exp_addr = 6'(FIRST);
        if (fft_read_address !== exp_addr) addr_bad++;
        busy_len++;
        if (exp_addr < 6'(LAST)) exp_addr = exp_addr + 6'd1;
      end else if (fft_read_address !== 6'd0) begin
        addr_bad++;
      end
      if (peak_valid) begin
        exp_t e;
        valid_cnt++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("peak_bin", peak_bin, e.bin);
          check("peak_mag", peak_mag, e.mag);
          check("peak_found", peak_found, e.found);
          check("valid_cycle", cyc, e.cyc);
          check("busy_len", busy_len, NB + 2);
          check("addr_seq_errs", addr_bad, 0);
          check("busy_at_valid", busy, 0);
        end
        busy_len = 0;
        addr_bad = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic clear_spec();
    for (int i = 0; i < 64; i++) spectrum[i] = 32'h0;
  endtask

  task automatic push_expected(input logic [31:0] thr, input int t);
    exp_t e;
    logic signed [15:0] re, im;
    logic [31:0] rr, ii, m;
    e.bin = 6'(FIRST);
    e.mag = 32'h0;
    for (int b = FIRST; b <= LAST; b++) begin
      re = spectrum[b][31:16];
      im = spectrum[b][15:0];
      rr = 32'(int'(re) * int'(re));
      ii = 32'(int'(im) * int'(im));
      m  = rr + ii;
      if (m > e.mag) begin
        e.mag = m;
        e.bin = 6'(b);
      end
    end
    e.found = (e.mag > thr);
    e.cyc   = t + NB + 3;
    sb.push_back(e);
  endtask

  // mode 0: plain; 1: extra rising edge at T+10; 2: fft_done held 100 cycles
  task automatic do_scan(input string tag, input logic [31:0] thr, input int mode);
    int t, hold, v0;
    v0 = valid_cnt;
    hold = (mode == 2) ? 100 : 45;
    @(posedge clk); #1;
    mag_threshold = thr;
    fft_done = 1'b1;
    t = cyc;
    push_expected(thr, t);
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (i == 5) mag_threshold = ~thr;
      if (mode == 1 && i == 8) fft_done = 1'b0;
      if (mode == 1 && i == 10) fft_done = 1'b1;
    end
    fft_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pending"}, sb.size(), 0);
    check({tag, "_valid_cnt"}, valid_cnt - v0, 1);
    sb.delete();
  endtask

  initial begin
    int t, v0;
    reset = 1'b1;
    fft_done = 1'b1;
    mag_threshold = 32'h0;
    clear_spec();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", peak_valid, 0);
    check("rst_found", peak_found, 0);
    check("rst_bin", peak_bin, 0);
    check("rst_mag", peak_mag, 0);
    check("rst_addr", fft_read_address, 0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("done_high_at_release_no_scan", valid_cnt, 0);
    check("done_high_at_release_busy", busy, 0);
    fft_done = 1'b0;
    repeat (2) @(posedge clk);

    clear_spec();
    spectrum[9] = 32'h4000_0000;
    do_scan("tone", 32'h0, 0);

    clear_spec();
    spectrum[5]  = 32'h0000_2000;
    spectrum[20] = 32'h0000_2000;
    spectrum[12] = 32'h1000_1000;
    do_scan("tie", 32'h0, 0);

    for (int i = 0; i < 64; i++) spectrum[i] = 32'h7FFF_7FFF;
    spectrum[31] = 32'h8000_8000;
    do_scan("extreme", 32'h0, 0);

    clear_spec();
    do_scan("zero", 32'h0, 0);

    spectrum[17] = 32'h0010_0000;
    do_scan("thr_equal", 32'h100, 0);
    do_scan("thr_below", 32'hFF, 0);

    clear_spec();
    spectrum[3]  = 32'hF000_0800;
    spectrum[28] = 32'h0C00_F400;
    do_scan("second_edge", 32'h0, 1);
    do_scan("held_100", 32'h0, 2);

    // Reset mid-scan: held results from the previous scan must clear
    spectrum[3] = 32'h2000_2000;
    @(posedge clk); #1;
    fft_done = 1'b1;
    t = cyc;
    v0 = valid_cnt;
    while (cyc < t + 15) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_addr", fft_read_address, 0);
    check("midrst_bin", peak_bin, 0);
    check("midrst_mag", peak_mag, 0);
    check("midrst_found", peak_found, 0);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_valid", valid_cnt - v0, 0);
    fft_done = 1'b0;
    repeat (2) @(posedge clk);
    do_scan("after_reset", 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_peak_detector.md
# fft_peak_detector

Downstream consumer of the 64-point FFT controller. On each completed transform, it scans the positive-frequency bins through the controller's read port and computes squared magnitude per bin. It reports the strongest bin index and its magnitude to the pitch-shift logic. One scan per FFT frame, fully pipelined at one bin per clock.

## Interface

Parameters:
- FIRST_BIN, default 1: first bin scanned (DC skipped).
- LAST_BIN, default 31: last bin scanned, inclusive. Requires FIRST_BIN ≤ LAST_BIN ≤ 63.

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fft_done  in  1  controller done flag (level); a scan starts on its rising edge.
- fft_read_address  out  6  bin address driven to controller read port.
- fft_data  in  32  bin data: [31:16] real, [15:0] imag, both signed Q1.15; valid one cycle after the address.
- mag_threshold  in  32  unsigned minimum magnitude for a valid peak; sampled at scan start.
- busy  out  1  high from scan start until peak_valid.
- peak_valid  out  1  one-cycle pulse when a result is published.
- peak_found  out  1  peak_mag > threshold; held.
- peak_bin  out  6  index of strongest bin; held.
- peak_mag  out  32  unsigned re²+im² of that bin; held.

## Operation

- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE: fft_read_address = 0 and busy = 0. The block registers fft_done into done_q. A rising edge (fft_done=1, done_q=0) moves to SCAN, latches mag_threshold, and clears the best registers: best_mag=0, best_bin=FIRST_BIN.
- SCAN: fft_read_address steps FIRST_BIN, FIRST_BIN+1, … LAST_BIN, one per cycle. After LAST_BIN is issued, the block goes to DRAIN.
- Pipeline for the address issued in cycle c:
  - fft_data is valid in cycle c+1.
  - re² and im² are registered at the end of c+1. Each is a 16×16 signed product held as 32-bit unsigned; the max is 2^30.
  - At the end of c+2, sum = re²+im² (32-bit unsigned, max 2^31, no overflow) is compared with best_mag. If sum > best_mag (strictly greater), best is updated with sum and the bin index.
- The bin index travels with the data through a 2-deep index pipeline.
- Ties: the lower bin is retained.
- DRAIN: 2 cycles to flush the pipeline. fft_read_address holds LAST_BIN.
- REPORT: 1 cycle. The block loads peak_bin, peak_mag and peak_found = (best_mag > latched threshold), and pulses peak_valid. It then returns to IDLE.
- A rising edge of fft_done while busy is ignored; it is neither queued nor restarts the scan.
- fft_done held high across multiple frames gives exactly one scan. A new scan needs fft_done to fall and rise again.
- All-zero spectrum: peak_bin = FIRST_BIN, peak_mag = 0, peak_found = 0.

## Timing

- Reset values:
  - Outputs: busy=0, peak_valid=0, peak_found=0, peak_bin=0, peak_mag=0, fft_read_address=0.
  - State = IDLE.
  - done_q = 1, so fft_done already high at reset release does not trigger a scan.
- Reset asserted mid-scan aborts the scan immediately. No peak_valid follows, and outputs return to their reset values.
- Edge sampled in cycle T:
  - busy = 1 and fft_read_address = FIRST_BIN from cycle T+1.
  - Last address is issued in cycle T+NB, where NB = LAST_BIN−FIRST_BIN+1.
  - peak_valid is high only in cycle T+NB+3; busy falls in the same cycle.
- Default latency: edge to peak_valid = 34 cycles.
- A new rising edge is accepted from cycle T+NB+4 onward.
- Held outputs change only in the peak_valid cycle or on reset.

## Test plan

- Single tone: bin 9 = (0x4000, 0x0000), all others 0, threshold 0, fft_done rises at cycle T. Required: peak_valid only at T+34, peak_bin=9, peak_mag=0x10000000, peak_found=1, addresses 1..31 issued in consecutive cycles.
- Tie and ordering: bins 5 and 20 = (0x0000, 0x2000), bin 12 = (0x1000, 0x1000). Required: peak_bin=5, peak_mag=0x04000000.
- Extreme values: bin 31 = (0x8000, 0x8000), others (0x7FFF, 0x7FFF). Required: peak_bin=31, peak_mag=0x80000000, no overflow.
- Threshold and zero spectrum:
  - All zero, threshold 0. Required: peak_found=0, peak_bin=1, peak_mag=0.
  - Tone of mag 0x100 with threshold 0x100. Required: peak_found=0.
- Handshake edges:
  - fft_done held high through reset release. Required: no scan.
  - Second rising edge at T+10. Required: ignored, exactly one peak_valid.
  - fft_done held high for 100 cycles. Required: one scan only.
- Reset at T+15 mid-scan. Required: busy=0 and address=0 the next cycle, no peak_valid, previous held results cleared to 0. A following fft_done edge scans normally.
